// File: rtl/key_filter_pkg.sv
// Shared types and helpers for the push-button conditioning path.
package key_filter_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_e;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchroniser, counter debounce FSM and press event.
// Optional auto-repeat counter is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_channel
  import key_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_key_n,
  output logic o_key_held,
  output logic o_press_event
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("key_debounce_channel: illegal parameter value");
  end

  logic          r_sync1, r_sync2;
  logic          w_s;
  chan_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_accept;

  // Synchroniser resets to the released (high) level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_key_held = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = cnt_width(RMAX);

  logic [RCW-1:0] r_rcnt;
  logic           r_rfirst;
  logic           w_repeat;

  // First repeat waits the long delay, later ones the shorter period.
  assign w_repeat = (r_state == PRESSED) &&
                    (r_rfirst ? (r_rcnt == RCW'(REPEAT_DELAY - 1))
                              : (r_rcnt == RCW'(REPEAT_PERIOD - 1)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b1;
    end else if (r_state == RELEASED || r_state == PRESS_WAIT) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b1;
    end else if (w_repeat) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b0;
    end else if (r_state == PRESSED) begin
      r_rcnt <= r_rcnt + RCW'(1);
    end
  end

  assign o_press_event = w_accept | w_repeat;
`else
  assign o_press_event = w_accept;
`endif

endmodule

// File: rtl/key_debounce_filter.sv
// Debounces NUM_KEYS active-low buttons and serialises press pulses, lowest index first.
// Auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce_filter
  import key_filter_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] posedge_key,
  output logic [NUM_KEYS-1:0] key_held
);

  logic [NUM_KEYS-1:0] w_event;
  logic [NUM_KEYS-1:0] w_grant;
  logic [NUM_KEYS-1:0] r_pending;
  logic [NUM_KEYS-1:0] r_posedge_key;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .i_key_n      (key_n[i]),
      .o_key_held   (key_held[i]),
      .o_press_event(w_event[i])
    );
  end

  // Isolate the lowest set pending bit; the rest wait for later cycles.
  assign w_grant = r_pending & (~r_pending + NUM_KEYS'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending     <= '0;
      r_posedge_key <= '0;
    end else begin
      r_pending     <= (r_pending & ~w_grant) | w_event;
      r_posedge_key <= w_grant;
    end
  end

  assign posedge_key = r_posedge_key;

endmodule

// File: tb/tb_key_debounce_filter.sv
// Scoreboard bench for key_debounce_filter: run-length reference model, queued expected pulses.
module tb_key_debounce_filter;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] posedge_key;
  logic [NK-1:0] key_held;

  always #5 clock = ~clock;

  key_debounce_filter #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .posedge_key(posedge_key),
    .key_held   (key_held)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NK-1:0] v;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: a key's level flips once the synchronised input has
  // disagreed with it for DB+1 consecutive samples; presses queue a pulse.
  int            cyc = 0;
  bit            m_h   [NK];
  int            m_run [NK];
  int            m_hold[NK];
  bit            m_q1  [NK] = '{default: 1'b1};
  bit            m_q2  [NK] = '{default: 1'b1};
  logic [NK-1:0] m_pend  = '0;
  logic [NK-1:0] m_ev;
  logic [NK-1:0] m_grant;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NK; k++) begin
        m_h[k] = 1'b0; m_run[k] = 0; m_hold[k] = 0; m_q1[k] = 1'b1; m_q2[k] = 1'b1;
      end
      m_pend = '0;
      exp_q.delete();
    end else begin
      cyc++;
      m_ev = '0;
      for (int k = 0; k < NK; k++) begin
        bit s;
        bit steady_pressed;
        s = !m_q2[k];
        steady_pressed = m_h[k] && (m_run[k] == 0);
        if (s != m_h[k]) m_run[k]++;
        else m_run[k] = 0;
`ifdef KEY_AUTOREPEAT_EN
        if (steady_pressed) begin
          m_hold[k]++;
          if (m_hold[k] == RD || (m_hold[k] > RD && (m_hold[k] - RD) % RP == 0)) m_ev[k] = 1'b1;
        end
`else
        if (steady_pressed) m_hold[k]++;
`endif
        if (m_run[k] == DB + 1) begin
          m_h[k] = s;
          m_run[k] = 0;
          m_hold[k] = 0;
          if (s) m_ev[k] = 1'b1;
        end
        m_q2[k] = m_q1[k];
        m_q1[k] = key_n[k];
      end
      m_grant = '0;
      for (int k = NK - 1; k >= 0; k--) if (m_pend[k]) m_grant = '0 | (NK'(1) << k);
      m_pend = (m_pend & ~m_grant) | m_ev;
      if (m_grant != '0) exp_q.push_back('{m_grant, cyc});
    end
  end

  int pulse_cyc[NK] = '{default: -1};
  int pulse_cnt[NK] = '{default: 0};

  always @(negedge clock) begin
    logic [NK-1:0] mh;
    for (int k = 0; k < NK; k++) mh[k] = m_h[k];
    checks++;
    if (key_held !== mh) begin
      failures++;
      $display("FAIL key_held cyc=%0d got=%b expected=%b", cyc, key_held, mh);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_pulse cyc=%0d got=none expected=%b@%0d", cyc, exp_q[0].v, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (posedge_key !== '0) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        if (posedge_key !== exp_q[0].v) begin
          failures++;
          $display("FAIL pulse_value cyc=%0d got=%b expected=%b", cyc, posedge_key, exp_q[0].v);
        end
        void'(exp_q.pop_front());
      end else begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b expected=0000", cyc, posedge_key);
      end
      for (int k = 0; k < NK; k++) if (posedge_key[k]) begin
        pulse_cnt[k]++;
        pulse_cyc[k] = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #2;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  int c0, base0, base1, base2, base3;

  initial begin
    reset = 1'b0;
    key_n = '1;
    tick(3);
    checks++;
    if (posedge_key !== '0 || key_held !== '0) begin
      failures++;
      $display("FAIL reset_state got=%b/%b expected=0000/0000", posedge_key, key_held);
    end
    reset = 1'b1;
    tick(3);

    // Single press on key 0
    base0 = pulse_cnt[0];
    key_n[0] = 1'b0;
    c0 = cyc + 1;
    tick(20);
    key_n[0] = 1'b1;
    tick(12);
    check_int("k0_pulse_count", pulse_cnt[0] - base0, 1);
    check_int("k0_latency", pulse_cyc[0] - c0, DB + 3);

    // Bouncing key 2
    base2 = pulse_cnt[2];
    for (int i = 0; i < 15; i++) begin
      key_n[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    key_n[2] = 1'b1;
    tick(10);
    check_int("k2_bounce_no_pulse", pulse_cnt[2] - base2, 0);

    // Simultaneous presses on keys 3 and 1
    base1 = pulse_cnt[1];
    base3 = pulse_cnt[3];
    key_n[3] = 1'b0;
    key_n[1] = 1'b0;
    c0 = cyc + 1;
    tick(20);
    key_n[3] = 1'b1;
    key_n[1] = 1'b1;
    tick(12);
    check_int("k1_arb_time", pulse_cyc[1] - c0, DB + 3);
    check_int("k3_arb_time", pulse_cyc[3] - c0, DB + 4);
    check_int("k1_arb_count", pulse_cnt[1] - base1, 1);
    check_int("k3_arb_count", pulse_cnt[3] - base3, 1);

    // Reset in the middle of a debounce count
    base0 = pulse_cnt[0];
    key_n[0] = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    c0 = cyc + 1;
    tick(15);
    key_n[0] = 1'b1;
    tick(12);
    check_int("reset_mid_count", pulse_cnt[0] - base0, 1);
    check_int("reset_restart_latency", pulse_cyc[0] - c0, DB + 3);

    // Short release glitch while key 1 is held
    key_n[1] = 1'b0;
    tick(12);
    base1 = pulse_cnt[1];
    key_n[1] = 1'b1;
    tick(2);
    key_n[1] = 1'b0;
    tick(10);
    check_int("glitch_no_repulse", pulse_cnt[1] - base1, 0);
    check_int("glitch_held", int'(key_held[1]), 1);
    key_n[1] = 1'b1;
    tick(12);

    // Long hold on key 0
    base0 = pulse_cnt[0];
    key_n[0] = 1'b0;
    c0 = cyc + 1;
    tick(60);
    key_n[0] = 1'b1;
    tick(12);
`ifdef KEY_AUTOREPEAT_EN
    check_int("long_hold_count", pulse_cnt[0] - base0, 6);
    check_int("long_hold_last", pulse_cyc[0] - c0, 59);
`else
    check_int("long_hold_count", pulse_cnt[0] - base0, 1);
    check_int("long_hold_last", pulse_cyc[0] - c0, DB + 3);
`endif

    // Random key activity against the model
    for (int seg = 0; seg < 150; seg++) begin
      key_n = NK'($urandom_range(0, (1 << NK) - 1));
      tick($urandom_range(1, 10));
    end
    key_n = '1;
    tick(20);

    while (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_pulse got=none expected=%b@%0d", exp_q[0].v, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
